machine_timer: RTL and testbench

Memory-mapped RISC-V machine timer sitting directly upstream of the core's `timer_interrupt` input. It holds a 64-bit `mtime` counter advanced by a programmable prescaler, plus a 64-bit `mtimecmp` compare register. It drives a registered level interrupt whenever `mtime >= mtimecmp` (unsigned). Software accesses it through a single-outstanding 32-bit register port behind the system bus.

---
 rtl/machine_timer.sv | 171 +++++++++++++++++
 tb/tb_machine_timer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// machine_timer: RISC-V machine timer with a 64-bit mtime counter, a
// programmable prescaler, a 64-bit mtimecmp compare register and a
// single-outstanding 32-bit register port. All outputs are registered.
module machine_timer #(
   parameter int PRESCALE_W   = 8,
   parameter bit RESET_ENABLE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        timer_interrupt
);

   localparam logic [2:0] SEL_MTIME_LO = 3'd0;
   localparam logic [2:0] SEL_MTIME_HI = 3'd1;
   localparam logic [2:0] SEL_CMP_LO   = 3'd2;
   localparam logic [2:0] SEL_CMP_HI   = 3'd3;
   localparam logic [2:0] SEL_CTRL     = 3'd4;

   // Replace each byte of old_v whose enable is set with the matching byte of new_v.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be_v);
      logic [31:0] res_v;
      for (int b = 0; b < 4; b++) begin
         res_v[8*b +: 8] = be_v[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res_v;
   endfunction

   logic [63:0]           mtime_r;
   logic [63:0]           mtimecmp_r;
   logic                  enable_r;
   logic [PRESCALE_W-1:0] div_r;
   logic [PRESCALE_W-1:0] pcnt_r;
   logic [31:0]           hi_shadow_r;
   logic                  ack_r;
   logic [31:0]           rdata_r;
   logic                  irq_r;

   logic                  acc_s;
   logic                  wr_acc_s;
   logic                  rd_acc_s;
   logic [2:0]            sel_s;
   logic                  tick_s;
   logic [31:0]           ctrl_word_s;
   logic [31:0]           rd_mux_s;
   logic [63:0]           mtime_nxt_s;
   logic [63:0]           mtimecmp_nxt_s;
   logic                  enable_nxt_s;
   logic [PRESCALE_W-1:0] div_nxt_s;
   logic [PRESCALE_W-1:0] pcnt_nxt_s;

   // A new access is taken only when no ack is being presented this cycle.
   assign acc_s    = req & ~ack_r;
   assign wr_acc_s = acc_s & wr;
   assign rd_acc_s = acc_s & ~wr;
   assign sel_s    = addr[4:2];
   assign tick_s   = enable_r & (pcnt_r == div_r);

   // Assemble the ctrl register image as software sees it.
   always_comb begin
      ctrl_word_s                   = 32'h0000_0000;
      ctrl_word_s[0]                = enable_r;
      ctrl_word_s[8 +: PRESCALE_W]  = div_r;
   end

   // Read data selection; mtime_hi returns the shadow captured by the last lo read.
   always_comb begin
      rd_mux_s = 32'h0000_0000;
      case (sel_s)
         SEL_MTIME_LO: rd_mux_s = mtime_r[31:0];
         SEL_MTIME_HI: rd_mux_s = hi_shadow_r;
         SEL_CMP_LO:   rd_mux_s = mtimecmp_r[31:0];
         SEL_CMP_HI:   rd_mux_s = mtimecmp_r[63:32];
         SEL_CTRL:     rd_mux_s = ctrl_word_s;
         default:      rd_mux_s = 32'h0000_0000;
      endcase
   end

   // Next mtime: a software write to either half wins and swallows a same-cycle tick.
   always_comb begin
      mtime_nxt_s = mtime_r;
      if (wr_acc_s && (sel_s == SEL_MTIME_LO)) begin
         mtime_nxt_s[31:0] = byte_merge(mtime_r[31:0], wdata, be);
      end else if (wr_acc_s && (sel_s == SEL_MTIME_HI)) begin
         mtime_nxt_s[63:32] = byte_merge(mtime_r[63:32], wdata, be);
      end else if (tick_s) begin
         mtime_nxt_s = mtime_r + 64'd1;
      end else begin
         mtime_nxt_s = mtime_r;
      end
   end

   // Next mtimecmp: byte-wise writes to either half.
   always_comb begin
      mtimecmp_nxt_s = mtimecmp_r;
      if (wr_acc_s && (sel_s == SEL_CMP_LO)) begin
         mtimecmp_nxt_s[31:0] = byte_merge(mtimecmp_r[31:0], wdata, be);
      end else if (wr_acc_s && (sel_s == SEL_CMP_HI)) begin
         mtimecmp_nxt_s[63:32] = byte_merge(mtimecmp_r[63:32], wdata, be);
      end else begin
         mtimecmp_nxt_s = mtimecmp_r;
      end
   end

   // Next ctrl and prescaler count; any ctrl write restarts the prescaler phase.
   always_comb begin
      enable_nxt_s = enable_r;
      div_nxt_s    = div_r;
      pcnt_nxt_s   = pcnt_r;
      if (wr_acc_s && (sel_s == SEL_CTRL)) begin
         enable_nxt_s = be[0] ? wdata[0] : enable_r;
         for (int i = 0; i < PRESCALE_W; i++) begin
            div_nxt_s[i] = be[(8 + i) / 8] ? wdata[8 + i] : div_r[i];
         end
         pcnt_nxt_s = {PRESCALE_W{1'b0}};
      end else if (tick_s) begin
         pcnt_nxt_s = {PRESCALE_W{1'b0}};
      end else if (enable_r) begin
         pcnt_nxt_s = pcnt_r + PRESCALE_W'(1);
      end else begin
         pcnt_nxt_s = pcnt_r;
      end
   end

   // Timer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_r     <= 64'h0000_0000_0000_0000;
         mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
         enable_r    <= RESET_ENABLE;
         div_r       <= {PRESCALE_W{1'b0}};
         pcnt_r      <= {PRESCALE_W{1'b0}};
         hi_shadow_r <= 32'h0000_0000;
      end else begin
         mtime_r    <= mtime_nxt_s;
         mtimecmp_r <= mtimecmp_nxt_s;
         enable_r   <= enable_nxt_s;
         div_r      <= div_nxt_s;
         pcnt_r     <= pcnt_nxt_s;
         if (rd_acc_s && (sel_s == SEL_MTIME_LO)) begin
            hi_shadow_r <= mtime_r[63:32];
         end
      end
   end

   // Registered bus response and interrupt compare on current register values.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_r   <= 1'b0;
         rdata_r <= 32'h0000_0000;
         irq_r   <= 1'b0;
      end else begin
         ack_r   <= acc_s;
         rdata_r <= rd_acc_s ? rd_mux_s : 32'h0000_0000;
         irq_r   <= (mtime_r >= mtimecmp_r);
      end
   end

   assign ack             = ack_r;
   assign rdata           = rdata_r;
   assign timer_interrupt = irq_r;

endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: directed test-plan scenarios followed by randomized bus
// traffic, every cycle checked against a behavioural model of the timer.
module tb_machine_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [4:0]  addr = 5'd0;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  be = 4'd0;
   logic        ack;
   logic [31:0] rdata;
   logic        timer_interrupt;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   logic [63:0] m_mtime, m_cmp;
   logic        m_en;
   int unsigned m_div, m_pcnt;
   logic [31:0] m_shadow, m_rdata;
   logic        m_ack, m_irq;
   logic [63:0] pre_mtime;

   machine_timer #(.PRESCALE_W(8), .RESET_ENABLE(1'b1)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .be(be), .ack(ack), .rdata(rdata), .timer_interrupt(timer_interrupt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] apply_be(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
      logic [31:0] r;
      r = o;
      if (b[0]) r[7:0]   = n[7:0];
      if (b[1]) r[15:8]  = n[15:8];
      if (b[2]) r[23:16] = n[23:16];
      if (b[3]) r[31:24] = n[31:24];
      return r;
   endfunction

   // Advance the model by one clock using the inputs about to be sampled.
   task automatic model_step();
      logic acc, tick;
      int idx;
      logic [31:0] rv, cw, nw;
      if (rst) begin
         m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 1'b1;
         m_div = 0; m_pcnt = 0; m_shadow = 32'd0;
         m_ack = 1'b0; m_rdata = 32'd0; m_irq = 1'b0;
      end else begin
         acc  = req && !m_ack;
         idx  = int'(addr[4:2]);
         tick = m_en && (m_pcnt == m_div);
         cw   = 32'((m_div << 8) | 32'(m_en));
         case (idx)
            0: rv = m_mtime[31:0];
            1: rv = m_shadow;
            2: rv = m_cmp[31:0];
            3: rv = m_cmp[63:32];
            4: rv = cw;
            default: rv = 32'd0;
         endcase
         m_irq   = (m_mtime >= m_cmp);
         m_ack   = acc;
         m_rdata = (acc && !wr) ? rv : 32'd0;
         if (acc && !wr && idx == 0) m_shadow = m_mtime[63:32];
         if (acc && wr && idx == 2) m_cmp[31:0]  = apply_be(m_cmp[31:0], wdata, be);
         if (acc && wr && idx == 3) m_cmp[63:32] = apply_be(m_cmp[63:32], wdata, be);
         if (acc && wr && idx == 4) begin
            nw = apply_be(cw, wdata, be);
            m_en = nw[0]; m_div = int'(nw[15:8]); m_pcnt = 0;
         end else if (tick) begin
            m_pcnt = 0;
         end else if (m_en) begin
            m_pcnt = (m_pcnt + 1) % 256;
         end
         if (acc && wr && idx == 0)      m_mtime[31:0]  = apply_be(m_mtime[31:0], wdata, be);
         else if (acc && wr && idx == 1) m_mtime[63:32] = apply_be(m_mtime[63:32], wdata, be);
         else if (tick)                  m_mtime = m_mtime + 64'd1;
      end
   endtask

   // One clock: step the model, let the DUT clock, compare all outputs.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_val("ack", ack, m_ack);
      check_val("rdata", rdata, m_rdata);
      check_val("irq", timer_interrupt, m_irq);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] rd);
      int n;
      req = 1'b1; wr = w; addr = a; wdata = d; be = b; n = 0;
      do begin
         pre_mtime = m_mtime;
         cycle();
         n++;
      end while (!ack && n < 4);
      if (!ack) check_val("ack_timeout", 64'd0, 64'd1);
      rd = rdata;
      req = 1'b0; wr = 1'b0;
   endtask

   initial begin
      logic [31:0] rd, va, vb;
      logic [63:0] old;
      int acks;

      // reset defaults
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(5);
      bus(1'b0, 5'h00, 32'd0, 4'h0, rd); check_val("rst_mtime5", rd, 64'd5);
      check_val("rst_irq", timer_interrupt, 64'd0);
      bus(1'b0, 5'h10, 32'd0, 4'h0, rd); check_val("rst_ctrl", rd, 64'h1);

      // prescale divide-by-4 and freeze
      bus(1'b1, 5'h10, 32'h0000_0301, 4'hF, rd);
      bus(1'b0, 5'h00, 32'd0, 4'h0, va);
      idle(39);
      bus(1'b0, 5'h00, 32'd0, 4'h0, vb);
      check_val("prescale_adv", vb - va, 64'd10);
      bus(1'b1, 5'h10, 32'h0000_0300, 4'hF, rd);
      bus(1'b0, 5'h00, 32'd0, 4'h0, va);
      idle(19);
      bus(1'b0, 5'h00, 32'd0, 4'h0, vb);
      check_val("freeze", vb, va);

      // compare and interrupt
      bus(1'b1, 5'h10, 32'h0, 4'hF, rd);
      bus(1'b1, 5'h00, 32'd90, 4'hF, rd);
      bus(1'b1, 5'h04, 32'd0, 4'hF, rd);
      bus(1'b1, 5'h08, 32'd100, 4'hF, rd);
      bus(1'b1, 5'h0C, 32'd0, 4'hF, rd);
      bus(1'b1, 5'h10, 32'h1, 4'hF, rd);
      for (int i = 1; i <= 11; i++) begin
         cycle();
         check_val("irq_rise", timer_interrupt, (i >= 11) ? 64'd1 : 64'd0);
      end
      bus(1'b1, 5'h0C, 32'd1, 4'hF, rd);
      check_val("irq_hold", timer_interrupt, 64'd1);
      cycle();
      check_val("irq_clear", timer_interrupt, 64'd0);

      // carry and atomic read
      bus(1'b1, 5'h10, 32'h0, 4'hF, rd);
      bus(1'b1, 5'h00, 32'hFFFF_FFFE, 4'hF, rd);
      bus(1'b1, 5'h04, 32'h0, 4'hF, rd);
      bus(1'b1, 5'h10, 32'h1, 4'hF, rd);
      idle(2);
      bus(1'b0, 5'h00, 32'd0, 4'h0, rd); check_val("carry_lo", rd, 64'd0);
      bus(1'b0, 5'h04, 32'd0, 4'h0, rd); check_val("carry_hi", rd, 64'd1);
      idle(5);
      bus(1'b0, 5'h04, 32'd0, 4'h0, rd); check_val("stale_hi", rd, 64'd1);

      // write vs tick collision, and no-op write that still loses the tick
      bus(1'b1, 5'h00, 32'h10, 4'h1, rd);
      old = pre_mtime;
      bus(1'b0, 5'h00, 32'd0, 4'h0, rd);
      old = ((old & 64'hFFFF_FFFF_FFFF_FF00) | 64'h10) + 64'd1;
      check_val("collide_lo", rd, {32'd0, old[31:0]});
      bus(1'b1, 5'h00, 32'hDEAD_BEEF, 4'h0, rd);
      old = pre_mtime;
      bus(1'b0, 5'h00, 32'd0, 4'h0, rd);
      old = old + 64'd1;
      check_val("be0_lo", rd, {32'd0, old[31:0]});

      // continuous request: one ack every other cycle
      idle(1);
      req = 1'b1; wr = 1'b0; addr = 5'h10; acks = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (ack) acks++;
      end
      req = 1'b0;
      check_val("b2b_acks", 64'(acks), 64'd4);
      idle(1);

      // reset arriving with a request discards it
      req = 1'b1; wr = 1'b1; addr = 5'h08; wdata = 32'h0; be = 4'hF; rst = 1'b1;
      cycle();
      check_val("rst_noack", ack, 64'd0);
      rst = 1'b0; req = 1'b0; wr = 1'b0;
      idle(1);
      bus(1'b0, 5'h08, 32'd0, 4'h0, rd); check_val("rst_cmp_lo", rd, 64'hFFFF_FFFF);
      bus(1'b0, 5'h10, 32'd0, 4'h0, rd); check_val("rst_ctrl2", rd, 64'h1);
      bus(1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, rd);
      bus(1'b0, 5'h14, 32'd0, 4'h0, rd); check_val("unmapped", rd, 64'd0);

      // randomized traffic
      for (int t = 0; t < 400; t++) begin
         int idx;
         logic [31:0] d;
         if ($urandom_range(0, 99) < 2) begin
            rst = 1'b1; cycle(); rst = 1'b0;
         end
         idle($urandom_range(0, 3));
         idx = $urandom_range(0, 7);
         case (idx)
            0: d = m_mtime[31:0] + 32'($urandom_range(0, 30));
            1: d = ($urandom_range(0, 3) == 0) ? $urandom : m_mtime[63:32];
            2: d = m_mtime[31:0] + 32'($urandom_range(0, 40));
            3: d = ($urandom_range(0, 3) == 0) ? $urandom : m_mtime[63:32];
            4: d = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) != 0));
            default: d = $urandom;
         endcase
         bus(1'($urandom_range(0, 1)), 5'((idx << 2) | $urandom_range(0, 3)), d,
             4'($urandom_range(0, 15)), rd);
      end
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
